// File: rtl/vga_pkg.sv
// Shared encodings and counter widths for the VGA display pipeline.
package vga_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 10;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_BLANK = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_BLANK    = 2'b01,
        ST_CLEARING = 2'b10
    } state_t;

endpackage

// File: rtl/vga_frame_det.sv
// Frame-start detector: one registered pulse per arrival of the counters at (0,0).
module vga_frame_det
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [HCNT_W-1:0] hcnt,
    input  logic [VCNT_W-1:0] vcnt,
    output logic              fs
);

    logic at_origin;
    logic seen;

    assign at_origin = (hcnt == '0) && (vcnt == '0);

    // 'seen' blocks repeat pulses while the counters sit at the origin (vga stalled).
    always_ff @(posedge clk) begin
        if (rst) begin
            seen <= 1'b0;
            fs   <= 1'b0;
        end else begin
            // NOTE: non-blocking so 'fs' uses the value of 'seen' from before this edge.
            seen <= at_origin;
            fs   <= at_origin & ~seen;
        end
    end

endmodule

// File: rtl/vga_seq.sv
// Display sequencer: applies RUN/BLANK/CLEAR commands at frame boundaries.
// Optional blink generator enabled by defining VGA_SEQ_BLINK_EN.
module vga_seq
    import vga_pkg::*;
#(
    parameter int CLEAR_FRAMES = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HCNT_W-1:0] hcnt,
    input  logic [VCNT_W-1:0] vcnt,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd,
    output logic              cmd_ready,
    output logic              enable,
    output logic              clear,
    output logic [7:0]        frame_cnt,
    output logic              busy,
    output logic              blink
);

    localparam logic [3:0] CLR_LOAD = 4'(CLEAR_FRAMES - 1);

    logic   fs;
    state_t state,    state_nx;
    state_t ret_mode, ret_mode_nx;
    cmd_t   pend_cmd, pend_cmd_nx;
    logic   pend_v,   pend_v_nx;
    logic [3:0] clr_cnt, clr_cnt_nx;

    vga_frame_det u_frame_det (
        .clk  (clk),
        .rst  (rst),
        .hcnt (hcnt),
        .vcnt (vcnt),
        .fs   (fs)
    );

    assign cmd_ready = ~pend_v;
    assign busy      = pend_v | (state == ST_CLEARING);

    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_nx    = state;
        ret_mode_nx = ret_mode;
        pend_cmd_nx = pend_cmd;
        pend_v_nx   = pend_v;
        clr_cnt_nx  = clr_cnt;

        // Accept needs an empty slot, apply needs a full one, so they never collide.
        if (cmd_valid && !pend_v && cmd_t'(cmd) != CMD_NOP) begin
            pend_v_nx   = 1'b1;
            pend_cmd_nx = cmd_t'(cmd);
        end

        if (fs) begin
            case (state)
                ST_RUN, ST_BLANK: begin
                    if (pend_v) begin
                        pend_v_nx = 1'b0;
                        case (pend_cmd)
                            CMD_RUN:   state_nx = ST_RUN;
                            CMD_BLANK: state_nx = ST_BLANK;
                            CMD_CLEAR: begin
                                state_nx    = ST_CLEARING;
                                ret_mode_nx = state;
                                clr_cnt_nx  = CLR_LOAD;
                            end
                            default:   state_nx = state;
                        endcase
                    end
                end
                ST_CLEARING: begin
                    if (clr_cnt == 4'd0) state_nx = ret_mode;
                    else                 clr_cnt_nx = clr_cnt - 4'd1;
                end
                default: state_nx = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            ret_mode  <= ST_RUN;
            pend_cmd  <= CMD_NOP;
            pend_v    <= 1'b0;
            clr_cnt   <= 4'd0;
            enable    <= 1'b1;
            clear     <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nx;
            ret_mode  <= ret_mode_nx;
            pend_cmd  <= pend_cmd_nx;
            pend_v    <= pend_v_nx;
            clr_cnt   <= clr_cnt_nx;
            enable    <= (state_nx != ST_BLANK);
            clear     <= (state_nx == ST_CLEARING);
            if (fs) frame_cnt <= frame_cnt + 8'd1;
        end
    end

`ifdef VGA_SEQ_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt;

    // Counts only frames that start in RUN; BLANK and CLEARING freeze the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= 8'd0;
            blink     <= 1'b0;
        end else if (fs && state == ST_RUN) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 8'd0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end
`else
    // Constant 0 for every legal BLINK_FRAMES (1..255).
    assign blink = (BLINK_FRAMES == 0);
`endif

endmodule

// File: tb/tb_vga_seq.sv
// Directed bench for vga_seq using a miniature 8x4 raster so frames are 32 cycles.
module tb_vga_seq;
    import vga_pkg::*;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        cmd_ready, enable, clear, busy, blink;
    logic [7:0]  frame_cnt;
    logic        stall = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int fc       = 0;

    vga_seq #(.CLEAR_FRAMES(2), .BLINK_FRAMES(30)) dut (
        .clk       (clk),
        .rst       (rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_ready (cmd_ready),
        .enable    (enable),
        .clear     (clear),
        .frame_cnt (frame_cnt),
        .busy      (busy),
        .blink     (blink)
    );

    always #10 clk = ~clk;

    // Raster counters: held while rst is high, optionally frozen at the origin.
    initial begin
        hcnt = 11'd5;
        vcnt = 10'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hcnt = 11'd5;
                vcnt = 10'd0;
            end else if (stall && hcnt == 11'd0 && vcnt == 10'd0) begin
                hcnt = 11'd0;
            end else if (hcnt == 11'(H - 1)) begin
                hcnt = 11'd0;
                vcnt = (vcnt == 10'(V - 1)) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt = hcnt + 11'd1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic check_out(input string tag, input logic en, input logic clr,
                             input logic rdy, input logic bsy);
        check({tag, ".enable"},    32'(enable),    32'(en));
        check({tag, ".clear"},     32'(clear),     32'(clr));
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(rdy));
        check({tag, ".busy"},      32'(busy),      32'(bsy));
    endtask

    // Returns #1 after the edge at which the DUT samples (0,0).
    task automatic next_origin();
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (hcnt == 11'd0 && vcnt == 10'd0) begin
                found = 1'b1;
                break;
            end
        end
        #1;
        if (!found) check("origin_timeout", 32'd0, 32'd1);
    endtask

    // Returns #1 after the edge where fs takes effect (outputs updated).
    task automatic next_frame();
        next_origin();
        @(posedge clk);
        #1;
        fc++;
    endtask

    task automatic send(input logic [1:0] c);
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        check("send.cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        fc = 0;
    endtask

    initial begin
        // Reset
        do_reset(3);
        check_out("reset", 1'b1, 1'b0, 1'b1, 1'b0);
        check("reset.frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset.blink", 32'(blink), 32'd0);

        next_frame();
        check("first_frame.frame_cnt", 32'(frame_cnt), 32'(fc));

        // BLANK mid-frame; enable drops one cycle after fs, not at fs
        send(CMD_BLANK);
        check_out("blank_pend", 1'b1, 1'b0, 1'b0, 1'b1);
        next_origin();
        check("blank_at_origin.enable", 32'(enable), 32'd1);
        @(posedge clk);
        #1;
        fc++;
        check_out("blank_applied", 1'b0, 1'b0, 1'b1, 1'b0);
        check("blank_applied.frame_cnt", 32'(frame_cnt), 32'(fc));

        send(CMD_RUN);
        next_frame();
        check_out("run_applied", 1'b1, 1'b0, 1'b1, 1'b0);
        send(CMD_BLANK);
        next_frame();
        check_out("blank2", 1'b0, 1'b0, 1'b1, 1'b0);

        // CLEAR from BLANK, with RUN queued during the clear
        send(CMD_CLEAR);
        next_frame();
        check_out("clr_f1", 1'b1, 1'b1, 1'b1, 1'b1);
        send(CMD_RUN);
        check_out("run_during_clr", 1'b1, 1'b1, 1'b0, 1'b1);
        next_frame();
        check_out("clr_f2", 1'b1, 1'b1, 1'b0, 1'b1);
        next_frame();
        check_out("clr_done_blank", 1'b0, 1'b0, 1'b0, 1'b1);
        next_frame();
        check_out("run_after_clr", 1'b1, 1'b0, 1'b1, 1'b0);
        check("run_after_clr.frame_cnt", 32'(frame_cnt), 32'(fc));

        // Accept in the same cycle fs is high: applied one frame later
        next_origin();
        cmd       = CMD_BLANK;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        fc++;
        check_out("acc_at_fs", 1'b1, 1'b0, 1'b0, 1'b1);
        next_frame();
        check_out("acc_at_fs_applied", 1'b0, 1'b0, 1'b1, 1'b0);

        // CLEAR issued during CLEARING restarts a clear returning to BLANK
        send(CMD_CLEAR);
        next_frame();
        check_out("clr2_f1", 1'b1, 1'b1, 1'b1, 1'b1);
        send(CMD_CLEAR);
        next_frame();
        check_out("clr2_f2", 1'b1, 1'b1, 1'b0, 1'b1);
        next_frame();
        check_out("clr2_back", 1'b0, 1'b0, 1'b0, 1'b1);
        next_frame();
        check_out("clr3_f1", 1'b1, 1'b1, 1'b1, 1'b1);
        next_frame();
        check_out("clr3_f2", 1'b1, 1'b1, 1'b1, 1'b1);
        next_frame();
        check_out("clr3_back_blank", 1'b0, 1'b0, 1'b1, 1'b0);

        send(CMD_RUN);
        next_frame();
        check_out("run3", 1'b1, 1'b0, 1'b1, 1'b0);

        // Counters stalled at the origin give exactly one fs
        stall = 1'b1;
        next_frame();
        repeat (40) @(posedge clk);
        #1;
        check("stall_single_fs.frame_cnt", 32'(frame_cnt), 32'(fc));
        stall = 1'b0;
        next_frame();
        check("stall_rearm.frame_cnt", 32'(frame_cnt), 32'(fc));

        // Reset during CLEARING with BLANK pending
        send(CMD_CLEAR);
        next_frame();
        check_out("clr4", 1'b1, 1'b1, 1'b1, 1'b1);
        send(CMD_BLANK);
        check("clr4_pend.busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out("rst_mid_clr", 1'b1, 1'b0, 1'b1, 1'b0);
        check("rst_mid_clr.frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fc  = 0;
        repeat (2) next_frame();
        check_out("post_rst", 1'b1, 1'b0, 1'b1, 1'b0);
        check("post_rst.frame_cnt", 32'(frame_cnt), 32'd2);

        // Frame counter wrap
        while (fc < 255) next_frame();
        check("wrap_255.frame_cnt", 32'(frame_cnt), 32'd255);
        next_frame();
        check("wrap_0.frame_cnt", 32'(frame_cnt), 32'd0);

`ifdef VGA_SEQ_BLINK_EN
        do_reset(3);
        repeat (29) next_frame();
        check("blink_f29", 32'(blink), 32'd0);
        next_frame();
        check("blink_f30", 32'(blink), 32'd1);
        send(CMD_BLANK);
        next_frame();
        repeat (39) next_frame();
        check("blink_frozen_blank", 32'(blink), 32'd1);
        send(CMD_RUN);
        next_frame();
        repeat (28) next_frame();
        check("blink_f99", 32'(blink), 32'd1);
        next_frame();
        check("blink_f100", 32'(blink), 32'd0);
`else
        check("blink_tied_low", 32'(blink), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_seq.md
# vga_seq

Display sequencer for the VGA pipeline. It accepts mode commands from game logic over a valid/ready handshake and applies them only at frame boundaries. It drives the `enable`/`clear` inputs of the `vga` block and provides frame-count and blink timing to the renderers. It sits between the game controller and `vga`, and watches `vga`'s `hcnt`/`vcnt` outputs.

## Interface
Parameters:
- `CLEAR_FRAMES`, default 2: number of whole frames `clear` is held for a CLEAR command (1..15).
- `BLINK_FRAMES`, default 30: frames per blink half-period (1..255). Used only with `VGA_SEQ_BLINK_EN`.

Ports (clock and reset first):
- `clk` in 1: system clock, 50 MHz; the same clock as `vga`.
- `rst` in 1: reset; synchronous, active-high.
- `hcnt` in 11: horizontal counter from `vga`.
- `vcnt` in 10: vertical counter from `vga`.
- `cmd_valid` in 1: command request.
- `cmd` in 2: command code; 00 NOP, 01 RUN, 10 BLANK, 11 CLEAR.
- `cmd_ready` out 1: a command is accepted on `cmd_valid & cmd_ready`.
- `enable` out 1: drives `vga.enable`.
- `clear` out 1: drives `vga.clear`.
- `frame_cnt` out 8: free-running frame counter.
- `busy` out 1: a command is pending or a clear is in progress.
- `blink` out 1: square wave at frame rate; tied 0 without `VGA_SEQ_BLINK_EN`.

## Operation
- **Frame start (`fs`):** a single-cycle internal pulse, registered. It asserts the cycle after `hcnt==0 && vcnt==0` is first seen, and re-arms only after that condition goes false.
- **Pending register:** one entry.
  - `cmd_ready = !pend_v`.
  - Accepting a command sets `pend_v` and `pend_cmd` on the next edge.
  - A NOP is accepted and dropped: `pend_v` is not set.
- **States:** RUN (`enable=1`, `clear=0`), BLANK (`enable=0`, `clear=0`), CLEARING (`enable=1`, `clear=1`).
- **In RUN or BLANK, on `fs` with `pend_v`:**
  - RUN goes to RUN; BLANK goes to BLANK.
  - CLEAR goes to CLEARING. It saves the prior mode in `ret_mode` and loads `clr_cnt = CLEAR_FRAMES-1`.
  - `pend_v` is cleared on the same edge.
- **In CLEARING, on `fs`:**
  - If `clr_cnt==0`, go to `ret_mode`; otherwise decrement `clr_cnt`.
  - A pending command is not applied in this state. It waits for the first `fs` after leaving CLEARING.
- **Frame counter:** `frame_cnt` increments on every `fs` in all states and wraps 255 to 0.
- **Busy:** `busy = pend_v | (state==CLEARING)`.

## Timing
- Reset values: state RUN, `enable=1`, `clear=0`, `cmd_ready=1`, `busy=0`, `frame_cnt=0`, `blink=0`, `pend_v=0`, `clr_cnt=0`, `ret_mode=RUN`.
- `fs` latency: 1 cycle after counters read (0,0).
- Outputs change 1 cycle after `fs`, i.e. 2 cycles after the counters read (0,0). All outputs are registered.
- Command accept to effect: at least 2 cycles. Worst case is one frame plus 2 cycles, or longer if CLEARING is active.
- Accept and `fs` in the same cycle: the command is not applied at that `fs`; it is applied at the next one.
- `cmd_valid` held while `cmd_ready=0`: no accept. The requester holds `cmd` stable until accepted.
- CLEAR issued while in CLEARING: stays pending, then starts a fresh CLEARING sequence with `ret_mode` equal to the mode just restored.
- `rst` mid-operation: all state returns to reset values on the next edge. The pending command is discarded.
- If `hcnt`/`vcnt` stall (`vga` held in reset), no `fs` occurs and commands stay pending indefinitely.

## Configuration
- `VGA_SEQ_BLINK_EN` defined:
  - An 8-bit `blink_cnt` counts `fs` pulses.
  - On reaching `BLINK_FRAMES-1` it reloads to 0 and `blink` toggles.
  - `blink_cnt` and `blink` freeze in BLANK and CLEARING, and resume on return to RUN.
- `VGA_SEQ_BLINK_EN` undefined: `blink` is constant 0 and there is no blink logic.

## Structure
- Package `vga_pkg`:
  - command encodings `CMD_NOP`, `CMD_RUN`, `CMD_BLANK`, `CMD_CLEAR`;
  - state encoding `ST_RUN`, `ST_BLANK`, `ST_CLEARING`;
  - timing widths `HCNT_W=11`, `VCNT_W=10`.
- Sub-module `vga_frame_det`: takes `clk`, `rst`, `hcnt`, `vcnt` and produces the `fs` pulse with the re-arm guard. It is reused by the renderers.

## Test plan
- **Reset:** assert `rst` 3 cycles, release → `enable=1`, `clear=0`, `cmd_ready=1`, `frame_cnt=0`, `busy=0`.
- **BLANK then RUN:** BLANK accepted mid-frame → `cmd_ready=0` until next `fs`; `enable` drops 2 cycles after (0,0) and `frame_cnt` increments by 1. RUN next frame → `enable=1`.
- **CLEAR from BLANK:** CLEAR with `CLEAR_FRAMES=2` → `clear=1`, `enable=1` for exactly 2 frames, then `enable=0`, `clear=0` (back to BLANK).
- **Command during clear:** RUN issued during CLEARING → stays pending (`busy=1`, `cmd_ready=0`); applied at the first `fs` after CLEARING ends. Also: command accepted in the exact `fs` cycle → applied at the following `fs`.
- **Wrap and blink:** run 256 frames → `frame_cnt` wraps to 0. With `VGA_SEQ_BLINK_EN` and `BLINK_FRAMES=30`, `blink` toggles every 30 frames and freezes during BLANK.
- **Reset mid-clear:** `rst` during CLEARING with a pending command → reset values next cycle; the pending command never takes effect.
